nano_bus_ctrl: RTL and testbench
================================

# nano_bus_ctrl

Parametrised data-bus controller placed between the nanoCPU data port and up to NUM_SLAVES memory-mapped slaves, such as data memory, seven-segment/switch I/O and a timer. It generalises the fixed single-memory data path of the single-cycle system into a decoded, handshaked bus:
- the CPU is stalled while an access is in flight;
- slaves may insert wait states;
- an unmapped address or a timed-out access completes with an error instead of hanging the CPU.

## Interface
Parameters:
- DATA_W, 32, data width of the CPU and slaves
- NUM_SLAVES, 4, number of slave channels (power of two, ≥2)
- SLV_ADDR_W, 16, byte-offset bits forwarded to each slave
- TIMEOUT, 15, maximum wait cycles in ACCESS before bus error (≥1)

Ports:
- clk, input, 1, system clock, rising edge
- nreset, input, 1, synchronous active-low reset
- d_address, input, 32, CPU byte address
- d_wdata, input, DATA_W, CPU write data
- mem_wr, input, 1, CPU write request
- mem_rd, input, 1, CPU read request
- d_rdata, output, DATA_W, read data to the CPU, valid when done=1
- stall, output, 1, holds the CPU while a request is pending
- done, output, 1, one-cycle completion pulse
- bus_err, output, 1, sticky error flag
- err_clr, input, 1, clears bus_err
- s_sel, output, NUM_SLAVES, one-hot slave select
- s_addr, output, SLV_ADDR_W, slave byte offset
- s_wdata, output, DATA_W, slave write data
- s_we, output, 1, slave write enable
- s_rdata, input, NUM_SLAVES*DATA_W, concatenated slave read data; slave i occupies bits [i*DATA_W +: DATA_W]
- s_ready, input, NUM_SLAVES, per-slave ready

## Operation
Address decode:
- req = mem_rd | mem_wr. If both are set, the access is a write.
- idx = d_address[SLV_ADDR_W +: log2(NUM_SLAVES)].
- Bits [31 : SLV_ADDR_W+log2(NUM_SLAVES)] must be zero; otherwise it is a decode error.

The controller has four states: IDLE, ACCESS, DONE and ERR.
- **IDLE:**
  - On req with a valid decode, latch idx, offset, wdata and we, clear the wait counter and go to ACCESS.
  - On req with a decode error, go to ERR.
- **ACCESS:**
  - Drives s_sel = 1<<idx, s_addr, s_wdata, and s_we = latched we.
  - When s_ready[idx]=1, capture that slave's s_rdata into d_rdata (reads only; writes keep the previous d_rdata) and go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT, go to ERR.
- **DONE:** done=1 and stall=0 for exactly one cycle, then go to IDLE.
- **ERR:**
  - bus_err is set and d_rdata = all-ones (ERR_DATA).
  - done=1 and stall=0 for one cycle, then go to IDLE.
  - No slave write is committed.

Other rules:
- stall = req & ~done, computed combinationally so the CPU freezes in the same cycle it asserts its request.
- The CPU must hold d_address, d_wdata, mem_wr and mem_rd stable while stall=1. Inputs are sampled only in IDLE.
- bus_err is cleared by err_clr=1 in a cycle where no error is being set; a new error wins over a simultaneous err_clr.
- A request arriving in the DONE or ERR cycle belongs to the CPU's current instruction and is not restarted. The next request is accepted in the following IDLE.

## Timing
- Reset (nreset=0 at a clk edge):
  - state goes to IDLE.
  - s_sel=0, s_we=0, s_addr=0, s_wdata=0, d_rdata=0, done=0, bus_err=0, counter=0.
  - stall follows req combinationally, since it is computed from req even in reset.
- Reset during ACCESS: slave select and s_we drop at that edge and there is no completion pulse.
- Latency with a zero-wait slave (ready in the first ACCESS cycle): request in cycle 0, ACCESS in cycle 1, done in cycle 2. That is 3 cycles, with stall high for cycles 0–1.
- Each wait cycle adds 1.
- Timeout: done occurs TIMEOUT+2 cycles after the request.
- Decode error: done occurs 2 cycles after the request (IDLE, ERR).
- s_we is high only in ACCESS cycles. Slaves commit a write on the edge at which s_ready=1.

## Structure
- Header nano_bus_defs.vh holds:
  - state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2, ERR=2'd3);
  - ERR_DATA (all-ones) for the error read value.
- Sub-module nano_bus_decode: combinational idx, offset and decode-error logic, parametrised by NUM_SLAVES and SLV_ADDR_W.
- The top level contains the FSM, wait counter, latches and read mux.

## Test plan
- **Read, zero wait:** NUM_SLAVES=4, slave 1 holds 32'hDEADBEEF at offset 0x10 with ready tied high. Read 0x0001_0010 → stall high for 2 cycles, done in cycle 2, d_rdata=32'hDEADBEEF, s_sel=4'b0010, s_we=0 throughout.
- **Write, 3 wait cycles:** write 32'h12345678 to 0x0000_0004, slave 0 raises ready on the 4th ACCESS cycle → s_we high for 4 cycles, done at cycle 5, memory[1]=32'h12345678, bus_err=0.
- **Decode error:** read 0x0004_0000 → no s_sel asserted, done at cycle 1, d_rdata=32'hFFFFFFFF, bus_err=1 until err_clr is pulsed.
- **Timeout:** TIMEOUT=15, slave 2 never ready → done at cycle 17, bus_err=1, d_rdata=all-ones.
- **Simultaneous rd+wr and reset:**
  - mem_rd=mem_wr=1 performs a write.
  - nreset=0 in the second ACCESS cycle → next cycle s_sel=0, state IDLE, no done pulse.
- **Back-to-back:** a held read followed by an immediate write → the second access starts in the IDLE cycle after done, with no lost or duplicated slave access.

Source files
------------

// File: rtl/nano_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nano_bus_ctrl_pkg
// Shared definitions for the nanoCPU data-bus controller:
//   - ADDR_W       : width of the CPU byte address
//   - bus_state_t  : controller state encoding (IDLE/ACCESS/DONE/ERR)
//   - clog2_min1() : ceil(log2(n)) clamped to at least 1 bit, used to size
//                    index and counter vectors
// ---------------------------------------------------------------------------
package nano_bus_ctrl_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } bus_state_t;

    // A zero-width vector is illegal, so tiny parameter values still get 1 bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nano_bus_decode.sv
// ---------------------------------------------------------------------------
// nano_bus_decode
// Purely combinational address decoder.
//   address : CPU byte address (ADDR_W bits)
//   idx     : slave index taken from the bits just above the slave offset
//   offset  : byte offset forwarded to the selected slave
//   dec_err : high when any address bit above the index field is set
// ---------------------------------------------------------------------------
module nano_bus_decode
    import nano_bus_ctrl_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int SLV_ADDR_W = 16,
    localparam int IDX_W     = clog2_min1(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     address,
    output logic [IDX_W-1:0]      idx,
    output logic [SLV_ADDR_W-1:0] offset,
    output logic                  dec_err
);

    assign offset = address[SLV_ADDR_W-1:0];
    assign idx    = address[SLV_ADDR_W +: IDX_W];

    // When offset + index already span the whole address there are no
    // upper bits left to check, and every address decodes.
    generate
        if (SLV_ADDR_W + IDX_W < ADDR_W) begin : g_hi_check
            assign dec_err = |address[ADDR_W-1:SLV_ADDR_W+IDX_W];
        end else begin : g_no_hi
            assign dec_err = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/nano_bus_ctrl.sv
// ---------------------------------------------------------------------------
// nano_bus_ctrl
// Data-bus controller between the nanoCPU data port and NUM_SLAVES
// memory-mapped slaves. The CPU is stalled while an access is in flight,
// slaves may insert wait states via s_ready, and unmapped addresses or
// accesses that exceed TIMEOUT wait cycles complete with a bus error.
//
// Ports:
//   clk, nreset            : clock (rising edge), synchronous active-low reset
//   d_address, d_wdata     : CPU byte address and write data
//   mem_wr, mem_rd         : CPU write / read request (both set => write)
//   d_rdata                : read data to CPU, valid while done=1
//   stall                  : holds the CPU while a request is pending
//   done                   : one-cycle completion pulse (DONE or ERR state)
//   bus_err, err_clr       : sticky error flag and its clear strobe
//   s_sel                  : one-hot slave select (ACCESS only)
//   s_addr, s_wdata, s_we  : slave offset, write data, write enable
//   s_rdata, s_ready       : concatenated slave read data, per-slave ready
// ---------------------------------------------------------------------------
module nano_bus_ctrl
    import nano_bus_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_ADDR_W = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic [ADDR_W-1:0]            d_address,
    input  logic [DATA_W-1:0]            d_wdata,
    input  logic                         mem_wr,
    input  logic                         mem_rd,
    output logic [DATA_W-1:0]            d_rdata,
    output logic                         stall,
    output logic                         done,
    output logic                         bus_err,
    input  logic                         err_clr,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [SLV_ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic                         s_we,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready
);

    localparam int IDX_W = clog2_min1(NUM_SLAVES);
    localparam int CNT_W = clog2_min1(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] ERR_DATA = '1;

    bus_state_t            state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg;
    logic [SLV_ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic                  we_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  bus_err_reg;

    logic                  req;
    logic [IDX_W-1:0]      dec_idx;
    logic [SLV_ADDR_W-1:0] dec_offset;
    logic                  dec_err;

    // FSM strobes for the datapath registers
    logic                  accept;
    logic                  capture;
    logic                  set_err;
    logic                  cnt_inc;

    logic [DATA_W-1:0]     slave_rdata [NUM_SLAVES];
    logic                  sel_ready;
    logic [DATA_W-1:0]     sel_rdata;

    assign req = mem_rd | mem_wr;

    nano_bus_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_ADDR_W (SLV_ADDR_W)
    ) u_decode (
        .address (d_address),
        .idx     (dec_idx),
        .offset  (dec_offset),
        .dec_err (dec_err)
    );

    // Split the flat read bus into one word per slave for the read mux.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rd_split
            assign slave_rdata[gi] = s_rdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign sel_ready = s_ready[idx_reg];
    assign sel_rdata = slave_rdata[idx_reg];

    // Next-state and output logic
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        cnt_inc    = 1'b0;
        done       = 1'b0;
        s_sel      = '0;
        s_we       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (dec_err) begin
                        state_next = ST_ERR;
                        set_err    = 1'b1;
                    end else begin
                        state_next = ST_ACCESS;
                        accept     = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                s_sel = NUM_SLAVES'(1) << idx_reg;
                s_we  = we_reg;
                // Ready is checked before the timeout, so a slave answering
                // in the very last allowed cycle still completes normally.
                if (sel_ready) begin
                    state_next = ST_DONE;
                    capture    = ~we_reg;
                end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    state_next = ST_ERR;
                    set_err    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Combinational so the CPU freezes in the same cycle it raises a request;
    // it is released in the completion cycle so the instruction can retire.
    assign stall   = req & ~done;
    assign s_addr  = addr_reg;
    assign s_wdata = wdata_reg;
    assign d_rdata = rdata_reg;
    assign bus_err = bus_err_reg;

    // State register and datapath latches
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            we_reg      <= 1'b0;
            cnt_reg     <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                idx_reg   <= dec_idx;
                addr_reg  <= dec_offset;
                wdata_reg <= d_wdata;
                we_reg    <= mem_wr;
                cnt_reg   <= '0;
            end else if (cnt_inc) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            // Error data is loaded on entry to ERR so it is valid with done.
            if (set_err) begin
                rdata_reg <= ERR_DATA;
            end else if (capture) begin
                rdata_reg <= sel_rdata;
            end

            // A new error takes priority over a simultaneous clear.
            if (set_err) begin
                bus_err_reg <= 1'b1;
            end else if (err_clr) begin
                bus_err_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nano_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nano_bus_ctrl
// Directed testbench for nano_bus_ctrl with default parameters
// (DATA_W=32, NUM_SLAVES=4, SLV_ADDR_W=16, TIMEOUT=15). Four slave memory
// models (16 words each) answer from s_addr[5:2]; their ready lines are
// driven directly by the stimulus. Inputs change on the falling edge and
// outputs are sampled 1 ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_nano_bus_ctrl;

    logic         clk = 1'b0;
    logic         nreset;
    logic [31:0]  d_address;
    logic [31:0]  d_wdata;
    logic         mem_wr;
    logic         mem_rd;
    logic [31:0]  d_rdata;
    logic         stall;
    logic         done;
    logic         bus_err;
    logic         err_clr;
    logic [3:0]   s_sel;
    logic [15:0]  s_addr;
    logic [31:0]  s_wdata;
    logic         s_we;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;

    int tests = 0;
    int fails = 0;

    // Slave models
    logic [31:0] mem [4][16];
    int          wr_count [4];
    int          rd_count [4];
    logic        loaded = 1'b0;

    always #5 clk = ~clk;

    nano_bus_ctrl dut (
        .clk       (clk),
        .nreset    (nreset),
        .d_address (d_address),
        .d_wdata   (d_wdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .d_rdata   (d_rdata),
        .stall     (stall),
        .done      (done),
        .bus_err   (bus_err),
        .err_clr   (err_clr),
        .s_sel     (s_sel),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_we      (s_we),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready)
    );

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 16; j++) begin
                    mem[i][j] <= 32'(32'hA000_0000 + i * 256 + j);
                end
                wr_count[i] <= 0;
                rd_count[i] <= 0;
            end
            mem[1][4] <= 32'hDEAD_BEEF;
            loaded    <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s_sel[i] && s_ready[i]) begin
                    if (s_we) begin
                        mem[i][s_addr[5:2]] <= s_wdata;
                        wr_count[i]         <= wr_count[i] + 1;
                    end else begin
                        rd_count[i] <= rd_count[i] + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        s_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            s_rdata[i*32 +: 32] = mem[i][s_addr[5:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nreset = 1'b0; d_address = '0; d_wdata = '0;
        mem_wr = 1'b0; mem_rd = 1'b0; err_clr = 1'b0; s_ready = '0;

        // ---------------- Reset state ----------------
        cyc(); cyc(); cyc(); #1;
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_s_sel",   s_sel, 0);
        chk("rst_s_we",    s_we, 0);
        chk("rst_s_addr",  s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_done",    done, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_stall0",  stall, 0);
        mem_rd = 1'b1; #1;
        chk("rst_stall_req", stall, 1);
        cyc(); mem_rd = 1'b0; nreset = 1'b1;

        // ---------------- Read, zero wait (slave 1) ----------------
        cyc(); s_ready = 4'b0010; d_address = 32'h0001_0010; mem_rd = 1'b1; #1;
        chk("rd0_c0_stall", stall, 1);
        chk("rd0_c0_sel",   s_sel, 0);
        cyc(); #1;
        chk("rd0_c1_sel",   s_sel, 4'b0010);
        chk("rd0_c1_we",    s_we, 0);
        chk("rd0_c1_addr",  s_addr, 16'h0010);
        chk("rd0_c1_stall", stall, 1);
        chk("rd0_c1_done",  done, 0);
        cyc(); #1;
        chk("rd0_c2_done",  done, 1);
        chk("rd0_c2_stall", stall, 0);
        chk("rd0_c2_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("rd0_c2_sel",   s_sel, 0);
        cyc(); mem_rd = 1'b0; #1;
        chk("rd0_c3_done",  done, 0);

        // ---------------- Write, 3 wait cycles (slave 0) ----------------
        cyc(); s_ready = 4'b0000; d_address = 32'h0000_0004; d_wdata = 32'h1234_5678; mem_wr = 1'b1; #1;
        chk("wr3_c0_stall", stall, 1);
        for (int c = 1; c <= 3; c++) begin
            cyc(); #1;
            chk("wr3_wait_we",    s_we, 1);
            chk("wr3_wait_sel",   s_sel, 4'b0001);
            chk("wr3_wait_stall", stall, 1);
            chk("wr3_wait_done",  done, 0);
        end
        cyc(); s_ready = 4'b0001; #1;
        chk("wr3_c4_we",    s_we, 1);
        chk("wr3_c4_wdata", s_wdata, 32'h1234_5678);
        cyc(); s_ready = 4'b0000; #1;
        chk("wr3_c5_done",  done, 1);
        chk("wr3_c5_we",    s_we, 0);
        chk("wr3_mem",      mem[0][1], 32'h1234_5678);
        chk("wr3_bus_err",  bus_err, 0);
        chk("wr3_rdata_kept", d_rdata, 32'hDEAD_BEEF);
        cyc(); mem_wr = 1'b0; #1;

        // ---------------- Decode error ----------------
        cyc(); d_address = 32'h0004_0000; mem_rd = 1'b1; #1;
        chk("dec_c0_stall", stall, 1);
        cyc(); #1;
        chk("dec_c1_done",  done, 1);
        chk("dec_c1_stall", stall, 0);
        chk("dec_c1_sel",   s_sel, 0);
        chk("dec_c1_rdata", d_rdata, 32'hFFFF_FFFF);
        chk("dec_c1_err",   bus_err, 1);
        cyc(); mem_rd = 1'b0; #1;
        chk("dec_err_sticky", bus_err, 1);
        chk("dec_c2_done",    done, 0);
        cyc(); err_clr = 1'b1; #1;
        chk("dec_err_pre_clr", bus_err, 1);
        cyc(); err_clr = 1'b0; #1;
        chk("dec_err_cleared", bus_err, 0);

        // ---------------- Timeout (slave 2 never ready) ----------------
        cyc(); d_address = 32'h0002_0008; mem_rd = 1'b1; #1;
        for (int c = 1; c <= 16; c++) begin
            cyc(); #1;
            chk("to_wait_done", done, 0);
            chk("to_wait_sel",  s_sel, 4'b0100);
            chk("to_wait_stall", stall, 1);
        end
        cyc(); #1;
        chk("to_c17_done",  done, 1);
        chk("to_c17_err",   bus_err, 1);
        chk("to_c17_rdata", d_rdata, 32'hFFFF_FFFF);
        chk("to_c17_sel",   s_sel, 0);
        cyc(); mem_rd = 1'b0; err_clr = 1'b1; #1;
        cyc(); err_clr = 1'b0; #1;
        chk("to_err_cleared", bus_err, 0);

        // ---------------- Simultaneous rd+wr performs a write ----------------
        cyc(); s_ready = 4'b0001; d_address = 32'h0000_0008; d_wdata = 32'hA5A5_5A5A;
        mem_rd = 1'b1; mem_wr = 1'b1; #1;
        cyc(); #1;
        chk("rw_c1_we",  s_we, 1);
        chk("rw_c1_sel", s_sel, 4'b0001);
        cyc(); #1;
        chk("rw_c2_done",  done, 1);
        chk("rw_mem",      mem[0][2], 32'hA5A5_5A5A);
        chk("rw_rdata_kept", d_rdata, 32'hFFFF_FFFF);
        cyc(); mem_rd = 1'b0; mem_wr = 1'b0; #1;

        // ---------------- Reset during ACCESS ----------------
        cyc(); s_ready = 4'b0000; d_address = 32'h0003_0000; d_wdata = 32'h1111_2222; mem_wr = 1'b1; #1;
        cyc(); #1;
        chk("rsta_c1_sel", s_sel, 4'b1000);
        cyc(); nreset = 1'b0; #1;
        chk("rsta_c2_sel", s_sel, 4'b1000);
        cyc(); #1;
        chk("rsta_c3_sel",   s_sel, 0);
        chk("rsta_c3_we",    s_we, 0);
        chk("rsta_c3_done",  done, 0);
        chk("rsta_c3_rdata", d_rdata, 0);
        chk("rsta_c3_stall", stall, 1);
        cyc(); nreset = 1'b1; mem_wr = 1'b0; #1;
        chk("rsta_c4_done",  done, 0);
        chk("rsta_mem",      mem[3][0], 32'hA000_0300);
        chk("rsta_wr_count", wr_count[3], 0);

        // ---------------- Back-to-back read then write ----------------
        cyc(); s_ready = 4'b0011; d_address = 32'h0001_0010; mem_rd = 1'b1; #1;
        cyc(); #1;
        chk("b2b_rd_sel", s_sel, 4'b0010);
        cyc(); #1;
        chk("b2b_rd_done",  done, 1);
        chk("b2b_rd_rdata", d_rdata, 32'hDEAD_BEEF);
        cyc(); mem_rd = 1'b0; mem_wr = 1'b1; d_address = 32'h0000_000C; d_wdata = 32'hCAFE_F00D; #1;
        chk("b2b_idle_stall", stall, 1);
        chk("b2b_idle_done",  done, 0);
        chk("b2b_idle_sel",   s_sel, 0);
        cyc(); #1;
        chk("b2b_wr_sel", s_sel, 4'b0001);
        chk("b2b_wr_we",  s_we, 1);
        cyc(); #1;
        chk("b2b_wr_done", done, 1);
        chk("b2b_wr_mem",  mem[0][3], 32'hCAFE_F00D);
        cyc(); mem_wr = 1'b0; #1;
        cyc(); #1;
        chk("b2b_wr_count0", wr_count[0], 3);
        chk("b2b_rd_count1", rd_count[1], 2);
        chk("b2b_final_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
